// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: ctrl encoding and BCD digit limits shared by the stopwatch blocks.
package stopwatch_pkg;
    typedef enum logic [1:0] {
        CTRL_NONE  = 2'd0,
        CTRL_START = 2'd1,
        CTRL_PAUSE = 2'd2,
        CTRL_STOP  = 2'd3
    } ctrl_e;
    localparam int BCD_W        = 4;
    localparam int CSEC_MAX     = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;
    function automatic logic [2*BCD_W-1:0] bcd2(input int v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction
endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// stopwatch_bcd_counter_if: tick/ctrl inputs and MM:SS.cc digit outputs of the BCD counter.
interface stopwatch_bcd_counter_if import stopwatch_pkg::*;;
    logic tick;
    ctrl_e ctrl;
`ifdef STOPWATCH_LAP_EN
    logic lap;
`endif
    logic [BCD_W-1:0] csec_lo, csec_hi, sec_lo, sec_hi, min_lo, min_hi;
    logic rollover, overflow;
    modport master (
        output tick, ctrl,
`ifdef STOPWATCH_LAP_EN
        output lap,
`endif
        input csec_lo, csec_hi, sec_lo, sec_hi, min_lo, min_hi, rollover, overflow
    );
    modport slave (
        input tick, ctrl,
`ifdef STOPWATCH_LAP_EN
        input lap,
`endif
        output csec_lo, csec_hi, sec_lo, sec_hi, min_lo, min_hi, rollover, overflow
    );
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit counting 0..LIMIT, carry = inc at LIMIT.
module bcd_digit import stopwatch_pkg::*; #(
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);
    assign carry = inc && (q == BCD_W'(LIMIT));
    always_ff @(posedge clk)
        if (!rst || clr) q <= '0;
        else if (inc) q <= carry ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: counts 10 ms ticks into BCD MM:SS.cc with rollover/overflow.
// Optional lap freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd_counter import stopwatch_pkg::*; #(
    parameter int MAX_MIN  = 59,
    parameter bit SATURATE = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    stopwatch_bcd_counter_if.slave bus
);
    localparam logic [2*BCD_W-1:0] MAX_BCD = bcd2(MAX_MIN);
    logic stop, at_max, min_max, inc, wrap;
    logic c0, c1, c2, c3, c4, c5;
    logic [BCD_W-1:0] cl, ch, sl, sh, ml, mh;
    logic [6*BCD_W-1:0] live, shown;
    assign stop    = bus.ctrl == CTRL_STOP;
    assign min_max = {mh, ml} == MAX_BCD;
    assign at_max  = min_max && sh == BCD_W'(SEC_TENS_MAX) && sl == BCD_W'(DIGIT_MAX)
                     && ch == BCD_W'(CSEC_MAX) && cl == BCD_W'(CSEC_MAX);
    // saturating counters simply stop incrementing once the maximum is reached
    assign inc  = bus.tick && !(SATURATE && at_max);
    assign wrap = c3 && (min_max || c5);
    bcd_digit #(.LIMIT(CSEC_MAX)) u_csec_lo (.clk(clk), .rst(rst), .clr(stop), .inc(inc), .q(cl), .carry(c0));
    bcd_digit #(.LIMIT(CSEC_MAX)) u_csec_hi (.clk(clk), .rst(rst), .clr(stop), .inc(c0), .q(ch), .carry(c1));
    bcd_digit #(.LIMIT(DIGIT_MAX)) u_sec_lo (.clk(clk), .rst(rst), .clr(stop), .inc(c1), .q(sl), .carry(c2));
    bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_sec_hi (.clk(clk), .rst(rst), .clr(stop), .inc(c2), .q(sh), .carry(c3));
    bcd_digit #(.LIMIT(DIGIT_MAX)) u_min_lo (.clk(clk), .rst(rst), .clr(stop || wrap), .inc(c3), .q(ml), .carry(c4));
    bcd_digit #(.LIMIT(DIGIT_MAX)) u_min_hi (.clk(clk), .rst(rst), .clr(stop || wrap), .inc(c4), .q(mh), .carry(c5));
    assign live = {mh, ml, sh, sl, ch, cl};
    always_ff @(posedge clk)
        if (!rst || stop) begin
            bus.rollover <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.rollover <= bus.tick && at_max && (!SATURATE || !bus.overflow);
            bus.overflow <= bus.overflow || (bus.tick && at_max);
        end
`ifdef STOPWATCH_LAP_EN
    logic lap_active;
    logic [6*BCD_W-1:0] freeze;
    always_ff @(posedge clk)
        if (!rst || stop) begin
            lap_active <= 1'b0;
            freeze     <= '0;
        end else if (bus.lap) begin
            lap_active <= !lap_active;
            if (!lap_active) freeze <= live;
        end
    assign shown = lap_active ? freeze : live;
`else
    assign shown = live;
`endif
    assign {bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo, bus.csec_hi, bus.csec_lo} = shown;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: directed checks on a wrapping (MAX_MIN=2) and a saturating (MAX_MIN=1) counter.
module tb_stopwatch_bcd_counter;
    import stopwatch_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [23:0] dw, ds;
    always #5 clk = ~clk;
    stopwatch_bcd_counter_if bw ();
    stopwatch_bcd_counter_if bs ();
    stopwatch_bcd_counter #(.MAX_MIN(2), .SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(bw.slave));
    stopwatch_bcd_counter #(.MAX_MIN(1), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
    assign dw = {bw.min_hi, bw.min_lo, bw.sec_hi, bw.sec_lo, bw.csec_hi, bw.csec_lo};
    assign ds = {bs.min_hi, bs.min_lo, bs.sec_hi, bs.sec_lo, bs.csec_hi, bs.csec_lo};
    function automatic logic [23:0] enc(input int c);
        int mm, ss, cc;
        mm = c / 6000;
        ss = (c / 100) % 60;
        cc = c % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction
    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic set_in(input logic t, input ctrl_e c, input logic l);
        bw.tick = t;
        bs.tick = t;
        bw.ctrl = c;
        bs.ctrl = c;
`ifdef STOPWATCH_LAP_EN
        bw.lap = l;
        bs.lap = l;
`else
        if (l) $display("lap ignored");
`endif
    endtask
    task automatic step(input logic t, input ctrl_e c, input logic l);
        set_in(t, c, l);
        @(posedge clk);
        #1;
        set_in(1'b0, c, 1'b0);
    endtask
    task automatic ticks(input int k);
        bw.tick = 1'b1;
        bs.tick = 1'b1;
        repeat (k) @(posedge clk);
        #1;
        bw.tick = 1'b0;
        bs.tick = 1'b0;
    endtask
    initial begin
        set_in(1'b1, CTRL_START, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_digits_w", dw, 24'h0);
        chk("rst_digits_s", ds, 24'h0);
        chk("rst_flags_w", {22'd0, bw.rollover, bw.overflow}, 24'h0);
        chk("rst_flags_s", {22'd0, bs.rollover, bs.overflow}, 24'h0);
        rst = 1'b1;
        set_in(1'b0, CTRL_START, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_after_rst", dw, 24'h0);
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, CTRL_START, 1'b0);
            chk("spaced_tick", dw, enc(i));
            @(posedge clk);
            #1;
            chk("spaced_hold", dw, enc(i));
            @(posedge clk);
            #1;
        end
        chk("one_second_w", dw, 24'h000100);
        chk("one_second_s", ds, 24'h000100);
        ticks(5899);
        chk("at_00_59_99", dw, 24'h005999);
        ticks(1);
        chk("carry_to_min", dw, 24'h010000);
        ticks(5999);
        chk("sat_at_max", ds, 24'h015999);
        chk("sat_no_ovf_yet", {22'd0, bs.rollover, bs.overflow}, 24'h0);
        ticks(1);
        chk("sat_hold", ds, 24'h015999);
        chk("sat_roll_ovf", {22'd0, bs.rollover, bs.overflow}, 24'h3);
        chk("wrap_passes_1min", dw, 24'h020000);
        chk("wrap_no_roll", {23'd0, bw.rollover}, 24'h0);
        ticks(1);
        chk("sat_hold2", ds, 24'h015999);
        chk("sat_no_reroll", {22'd0, bs.rollover, bs.overflow}, 24'h1);
        ticks(5998);
        chk("wrap_at_max", dw, 24'h025999);
        chk("wrap_no_ovf_yet", {23'd0, bw.overflow}, 24'h0);
        ticks(1);
        chk("wrap_to_zero", dw, 24'h0);
        chk("wrap_roll_ovf", {22'd0, bw.rollover, bw.overflow}, 24'h3);
        step(1'b0, CTRL_NONE, 1'b0);
        chk("wrap_roll_pulse", {22'd0, bw.rollover, bw.overflow}, 24'h1);
        set_in(1'b0, CTRL_PAUSE, 1'b0);
        ticks(1234);
        chk("pause_counts", dw, 24'h001234);
        chk("sat_still_held", ds, 24'h015999);
        step(1'b1, CTRL_STOP, 1'b0);
        chk("stop_w", dw, 24'h0);
        chk("stop_s", ds, 24'h0);
        chk("stop_flags_w", {22'd0, bw.rollover, bw.overflow}, 24'h0);
        chk("stop_flags_s", {22'd0, bs.rollover, bs.overflow}, 24'h0);
        step(1'b1, CTRL_NONE, 1'b0);
        chk("after_stop_w", dw, 24'h000001);
        chk("after_stop_s", ds, 24'h000001);
`ifdef STOPWATCH_LAP_EN
        ticks(249);
        chk("pre_lap", dw, 24'h000250);
        step(1'b0, CTRL_NONE, 1'b1);
        ticks(30);
        chk("lap_frozen", dw, 24'h000250);
        step(1'b0, CTRL_NONE, 1'b1);
        chk("lap_release", dw, 24'h000280);
        step(1'b1, CTRL_NONE, 1'b1);
        chk("lap_with_tick", dw, 24'h000280);
        ticks(5);
        chk("lap_frozen2", dw, 24'h000280);
        step(1'b0, CTRL_STOP, 1'b0);
        chk("lap_stop", dw, 24'h0);
        step(1'b1, CTRL_NONE, 1'b0);
        chk("lap_cleared", dw, 24'h000001);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
